// File: rtl/music_seq.sv
// Note sequencer: plays stored songs of {value, tone, dur} notes, one beat every
// BEAT_DIV clocks, with play/pause/stop control and optional looping.
module music_seq #(
    parameter int VAL_W     = 3,
    parameter int TONE_W    = 2,
    parameter int DUR_W     = 2,
    parameter int DEPTH     = 32,
    parameter int NUM_SONGS = 4,
    parameter int BEAT_DIV  = 262144,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = $clog2(NUM_SONGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_song,
    input  logic [AW-1:0]     wr_addr,
    input  logic [VAL_W-1:0]  wr_value,
    input  logic [TONE_W-1:0] wr_tone,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic              len_we,
    input  logic [AW:0]       len_val,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop,
    input  logic [SW-1:0]     song_sel,
    output logic [VAL_W-1:0]  value_out,
    output logic [TONE_W-1:0] tone_out,
    output logic              busy,
    output logic [AW-1:0]     note_idx,
    output logic              done
);
    localparam int NW = VAL_W + TONE_W + DUR_W;
    localparam int BW = $clog2(BEAT_DIV);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2} state_t;

    state_t           state;
    logic [NW-1:0]    mem [NUM_SONGS*DEPTH];
    logic [AW:0]      len_r [NUM_SONGS];
    logic [SW-1:0]    cur_song;
    logic [BW-1:0]    beat_cnt;
    logic [DUR_W-1:0] dur_cnt;
    logic [VAL_W-1:0] note_val;
    logic [TONE_W-1:0] note_tone;
    logic [DUR_W-1:0] note_dur;

    logic             start_ok, note_end, last_note, advance, fetch_en;
    logic [SW-1:0]    fetch_song;
    logic [AW-1:0]    fetch_idx;
    logic [NW-1:0]    fetch_word;
    logic [AW:0]      len_wr;

    assign len_wr    = (len_val > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len_val;
    assign start_ok  = (state == IDLE) && play && (len_r[song_sel] != '0);
    assign note_end  = (state == PLAY) && !stop && !pause &&
                       (beat_cnt == BW'(BEAT_DIV - 1)) && (dur_cnt == note_dur);
    // Length is read live so a shortened song ends when the current note ends.
    assign last_note = ({1'b0, note_idx} + 1'b1) >= len_r[cur_song];
    assign advance   = note_end && (!last_note || loop);

    always_comb begin
        fetch_en   = start_ok || advance;
        fetch_song = start_ok ? song_sel : cur_song;
        fetch_idx  = (start_ok || last_note) ? '0 : note_idx + 1'b1;
    end

    assign fetch_word = mem[{fetch_song, fetch_idx}];

    // Note storage and the latched current note carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_song, wr_addr}] <= {wr_value, wr_tone, wr_dur};
        if (fetch_en)
            {note_val, note_tone, note_dur} <= fetch_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_song  <= '0;
            note_idx  <= '0;
            beat_cnt  <= '0;
            dur_cnt   <= '0;
            value_out <= '0;
            tone_out  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_SONGS; i++)
                len_r[i] <= '0;
        end else begin
            done <= 1'b0;
            if (len_we)
                len_r[wr_song] <= len_wr;
            case (state)
                IDLE: begin
                    if (play) begin
                        cur_song <= song_sel;
                        if (len_r[song_sel] == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= PLAY;
                            busy      <= 1'b1;
                            note_idx  <= '0;
                            beat_cnt  <= '0;
                            dur_cnt   <= '0;
                            value_out <= fetch_word[NW-1 -: VAL_W];
                            tone_out  <= fetch_word[DUR_W +: TONE_W];
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        note_idx  <= '0;
                        beat_cnt  <= '0;
                        dur_cnt   <= '0;
                        value_out <= '0;
                        tone_out  <= '0;
                    end else if (pause) begin
                        state     <= PAUSE;
                        value_out <= '0;
                        tone_out  <= '0;
                    end else if (beat_cnt == BW'(BEAT_DIV - 1)) begin
                        beat_cnt <= '0;
                        if (dur_cnt == note_dur) begin
                            dur_cnt <= '0;
                            if (last_note && !loop) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                note_idx  <= '0;
                                value_out <= '0;
                                tone_out  <= '0;
                            end else begin
                                note_idx  <= fetch_idx;
                                value_out <= fetch_word[NW-1 -: VAL_W];
                                tone_out  <= fetch_word[DUR_W +: TONE_W];
                            end
                        end else begin
                            dur_cnt <= dur_cnt + 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        note_idx  <= '0;
                        beat_cnt  <= '0;
                        dur_cnt   <= '0;
                    end else if (play) begin
                        state     <= PLAY;
                        value_out <= note_val;
                        tone_out  <= note_tone;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_music_seq.sv
// Bench for music_seq: per-cycle expected outputs from a note-time reference model
// are queued by the driver and compared by an independent negedge monitor.
module tb_music_seq;
    localparam int VAL_W = 3, TONE_W = 2, DUR_W = 2, DEPTH = 32, NUM_SONGS = 4;
    localparam int BEAT_DIV = 4, AW = 5, SW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0, len_we = 1'b0;
    logic [SW-1:0]     wr_song = '0, song_sel = '0;
    logic [AW-1:0]     wr_addr = '0;
    logic [VAL_W-1:0]  wr_value = '0;
    logic [TONE_W-1:0] wr_tone = '0;
    logic [DUR_W-1:0]  wr_dur = '0;
    logic [AW:0]       len_val = '0;
    logic              play = 1'b0, pause = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [VAL_W-1:0]  value_out;
    logic [TONE_W-1:0] tone_out;
    logic              busy, done;
    logic [AW-1:0]     note_idx;

    music_seq #(.VAL_W(VAL_W), .TONE_W(TONE_W), .DUR_W(DUR_W), .DEPTH(DEPTH),
                .NUM_SONGS(NUM_SONGS), .BEAT_DIV(BEAT_DIV)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_song(wr_song), .wr_addr(wr_addr),
        .wr_value(wr_value), .wr_tone(wr_tone), .wr_dur(wr_dur), .len_we(len_we),
        .len_val(len_val), .play(play), .pause(pause), .stop(stop), .loop(loop),
        .song_sel(song_sel), .value_out(value_out), .tone_out(tone_out), .busy(busy),
        .note_idx(note_idx), .done(done));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int tag; logic [11:0] o; } exp_t;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] dut_outs();
        return {value_out, tone_out, busy, note_idx, done};
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got val=%0d tone=%0d busy=%0d idx=%0d done=%0d | exp val=%0d tone=%0d busy=%0d idx=%0d done=%0d",
                     name, cyc, got[11:9], got[8:7], got[6], got[5:1], got[0],
                     exp[11:9], exp[8:7], exp[6], exp[5:1], exp[0]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            check("outs", dut_outs(), e.o);
        end
    end

    // Reference model: tracks play time elapsed inside the current note in clock cycles.
    int m_mode, m_song, m_idx, m_el, m_val, m_tone, m_dur;
    int m_len [NUM_SONGS];
    int mv [NUM_SONGS][DEPTH];
    int mt [NUM_SONGS][DEPTH];
    int md [NUM_SONGS][DEPTH];

    task automatic load_note(int s, int i);
        m_val = mv[s][i]; m_tone = mt[s][i]; m_dur = md[s][i];
    endtask

    task automatic go_idle();
        m_mode = 0; m_idx = 0; m_el = 0;
    endtask

    task automatic model_reset();
        go_idle();
        m_song = 0;
        for (int s = 0; s < NUM_SONGS; s++) m_len[s] = 0;
    endtask

    task automatic model_step();
        int d;
        int l;
        exp_t e;
        d = 0;
        case (m_mode)
            0: if (play) begin
                m_song = int'(song_sel);
                if (m_len[m_song] == 0) d = 1;
                else begin m_mode = 1; m_idx = 0; m_el = 0; load_note(m_song, 0); end
            end
            1: if (stop) go_idle();
               else if (pause) m_mode = 2;
               else begin
                   m_el++;
                   if (m_el == (m_dur + 1) * BEAT_DIV) begin
                       m_el = 0;
                       if (m_idx + 1 >= m_len[m_song]) begin
                           if (loop) begin m_idx = 0; load_note(m_song, 0); end
                           else begin go_idle(); d = 1; end
                       end else begin
                           m_idx++; load_note(m_song, m_idx);
                       end
                   end
               end
            default: if (stop) go_idle();
                     else if (play) m_mode = 1;
        endcase
        if (wr_en) begin
            mv[wr_song][wr_addr] = int'(wr_value);
            mt[wr_song][wr_addr] = int'(wr_tone);
            md[wr_song][wr_addr] = int'(wr_dur);
        end
        if (len_we) begin
            l = int'(len_val);
            m_len[wr_song] = (l > DEPTH) ? DEPTH : l;
        end
        e.tag = cyc + 1;
        e.o = {3'((m_mode == 1) ? m_val : 0), 2'((m_mode == 1) ? m_tone : 0),
               1'(m_mode != 0), 5'(m_idx), 1'(d)};
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        play = 0; pause = 0; stop = 0; wr_en = 0; len_we = 0;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic wnote(int s, int a, int v, int t, int d);
        wr_en = 1; wr_song = 2'(s); wr_addr = 5'(a);
        wr_value = 3'(v); wr_tone = 2'(t); wr_dur = 2'(d);
        tick();
    endtask

    task automatic wlen(int s, int l);
        len_we = 1; wr_song = 2'(s); len_val = 6'(l);
        tick();
    endtask

    task automatic do_play(int s);
        song_sel = 2'(s); play = 1;
        tick();
    endtask

    // Entered just after an edge with nothing queued for the next one.
    task automatic do_reset();
        #6;
        rst = 1;
        #1;
        check("async_reset_outs", dut_outs(), 12'h000);
        @(posedge clk);
        #1;
        check("reset_hold_outs", dut_outs(), 12'h000);
        #3;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d expected bench to finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst = 1;
        #2 check("reset_outs", dut_outs(), 12'h000);
        @(posedge clk);
        #1 check("reset_hold_outs", dut_outs(), 12'h000);
        #3 rst = 0;
        @(posedge clk);
        #1;

        for (int s = 0; s < NUM_SONGS; s++)
            for (int a = 0; a < DEPTH; a++)
                wnote(s, a, $urandom_range(7), $urandom_range(3), $urandom_range(3));
        wnote(1, 0, 3, 3, 0);
        wnote(1, 1, 2, 3, 1);
        wlen(1, 2);
        wlen(2, 40);
        wlen(0, 5);

        loop = 0; do_play(1); run(16);
        loop = 1; do_play(1); run(40); stop = 1; tick(); run(3);
        loop = 0; do_play(1); run(2); pause = 1; tick(); run(10); play = 1; tick(); run(14);
        do_play(1); run(3); play = 1; stop = 1; tick(); run(3);
        do_play(1); run(1); pause = 1; play = 1; tick(); run(2);
        song_sel = 2'd2; play = 1; tick(); run(3); pause = 1; tick(); stop = 1; tick(); run(2);
        do_play(3); run(3);
        do_play(2); run(DEPTH * 16 + 10);
        loop = 1; do_play(0); run(5);
        wnote(0, 1, 7, 1, 2); wnote(0, 0, 5, 2, 0);
        run(60); wlen(0, 1); run(40);
        loop = 0; run(40);
        do_play(1); run(5);
        do_reset();
        do_play(1); run(3);

        for (int s = 0; s < NUM_SONGS; s++) wlen(s, $urandom_range(8, 1));
        for (int i = 0; i < 1500; i++) begin
            play  = ($urandom_range(15) == 0);
            pause = ($urandom_range(23) == 0);
            stop  = ($urandom_range(59) == 0);
            song_sel = 2'($urandom);
            if ($urandom_range(31) == 0) loop = ~loop;
            wr_en = ($urandom_range(7) == 0);
            wr_song = 2'($urandom); wr_addr = 5'($urandom);
            wr_value = 3'($urandom); wr_tone = 2'($urandom); wr_dur = 2'($urandom);
            len_we = ($urandom_range(79) == 0);
            len_val = 6'($urandom_range(40));
            tick();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
